vpic_n: RTL and testbench

Parametrised multi-channel vectored priority interrupt controller; the next generation of the processor's fixed 4-input hardware vector priority interrupt system. It adds per-channel edge/level mode, an in-service register for nested interrupts, and an explicit acknowledge/return handshake with the controller. It sits beside the controller: it drives `i_pending` and the jump vector into the PC mux path and receives `i_ack`/`i_ret` from the control sequence.

---
 rtl/vpic_n_if.sv | 27 ++
 rtl/vpic_n.sv | 66 ++++++
 tb/tb_vpic_n.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vpic_n_if.sv
// vpic_n_if: request, handshake and status signals between the interrupt controller and the processor control path
interface vpic_n_if #(
    parameter int N_CH    = 4,
    parameter int V_WIDTH = 8
);
    logic [N_CH-1:0]    irq_in;
    logic [N_CH-1:0]    edge_mode;
    logic               mask_wr;
    logic [N_CH-1:0]    mask_in;
    logic               i_en;
    logic               i_ack;
    logic               i_ret;
    logic               i_pending;
    logic [V_WIDTH-1:0] vector_out;
    logic [N_CH-1:0]    isr_out;
    logic [N_CH-1:0]    mask_out;

    modport master (
        output irq_in, edge_mode, mask_wr, mask_in, i_en, i_ack, i_ret,
        input  i_pending, vector_out, isr_out, mask_out
    );

    modport slave (
        input  irq_in, edge_mode, mask_wr, mask_in, i_en, i_ack, i_ret,
        output i_pending, vector_out, isr_out, mask_out
    );
endinterface

// File: rtl/vpic_n.sv
// vpic_n: vectored priority interrupt controller with edge/level channels, masking and nested in-service tracking
module vpic_n #(
    parameter int                 N_CH       = 4,
    parameter int                 V_WIDTH    = 8,
    parameter logic [V_WIDTH-1:0] VEC_BASE   = 8'hF0,
    parameter int                 VEC_STRIDE = 1
) (
    input logic     g_clk,
    input logic     g_clr,
    vpic_n_if.slave bus
);
    logic [N_CH-1:0]    irq_q;
    logic [N_CH-1:0]    pend;
    logic [N_CH-1:0]    mask;
    logic [N_CH-1:0]    isr;
    logic [N_CH-1:0]    req;
    logic [N_CH-1:0]    isr_low;
    logic [N_CH-1:0]    below;
    logic [N_CH-1:0]    elig;
    logic [N_CH-1:0]    win;
    logic [N_CH-1:0]    rise;
    logic [N_CH-1:0]    ack_clr;
    logic [N_CH-1:0]    ret_clr;
    logic               take;
    logic [V_WIDTH-1:0] win_vec;

    // isr_low isolates the active priority level; subtracting one yields every strictly higher
    // priority channel, and wraps to all-ones when nothing is in service
    assign req     = pend & ~mask;
    assign isr_low = isr & (~isr + N_CH'(1));
    assign below   = isr_low - N_CH'(1);
    assign elig    = req & below;
    assign win     = elig & (~elig + N_CH'(1));
    assign rise    = bus.irq_in & ~irq_q;
    assign take    = bus.i_ack & bus.i_pending;
    assign ack_clr = take ? win : '0;
    assign ret_clr = bus.i_ret ? isr_low : '0;

    // vector of the one-hot winner, wrapping modulo the vector width
    always_comb begin
        win_vec = '0;
        for (int c = 0; c < N_CH; c++)
            win_vec = win[c] ? V_WIDTH'(int'(VEC_BASE) + c * VEC_STRIDE) : win_vec;
    end

    assign bus.i_pending  = bus.i_en & |elig;
    assign bus.vector_out = bus.i_pending ? win_vec : '0;
    assign bus.isr_out    = isr;
    assign bus.mask_out   = mask;

    // edge channels latch until taken (a fresh edge on the taken channel survives); level channels follow the line
    always_ff @(posedge g_clk) begin
        if (g_clr) begin
            irq_q <= '0;
            pend  <= '0;
            isr   <= '0;
            mask  <= '1;
        end else begin
            irq_q <= bus.irq_in;
            pend  <= (bus.edge_mode & ((pend & ~ack_clr) | rise)) | (~bus.edge_mode & bus.irq_in);
            isr   <= (isr & ~ret_clr) | ack_clr;
            if (bus.mask_wr)
                mask <= bus.mask_in;
        end
    end
endmodule

// File: tb/tb_vpic_n.sv
// tb_vpic_n: directed scenarios plus randomized run against a rule-level model of the interrupt controller
module tb_vpic_n;
    logic g_clk = 1'b0;
    logic g_clr = 1'b0;
    logic g_clr_b = 1'b0;
    int checks = 0;
    int errors = 0;

    vpic_n_if #(.N_CH(4), .V_WIDTH(8)) ia();
    vpic_n_if #(.N_CH(8), .V_WIDTH(8)) ib();

    vpic_n #(.N_CH(4), .V_WIDTH(8), .VEC_BASE(8'hF0), .VEC_STRIDE(1)) dut_a (
        .g_clk(g_clk), .g_clr(g_clr), .bus(ia.slave)
    );
    vpic_n #(.N_CH(8), .V_WIDTH(8), .VEC_BASE(8'hFC), .VEC_STRIDE(2)) dut_b (
        .g_clk(g_clk), .g_clr(g_clr_b), .bus(ib.slave)
    );

    always #5 g_clk = ~g_clk;

    initial begin
        #2000000;
        $display("FAIL timeout reached before summary");
        $fatal(1);
    end

    bit m_prev[4];
    bit m_pend[4];
    bit m_isr[4];
    bit m_mask[4];

    function automatic int m_win();
        int p = 4;
        int w = -1;
        for (int c = 3; c >= 0; c--) if (m_isr[c]) p = c;
        for (int c = p - 1; c >= 0; c--) if (m_pend[c] && !m_mask[c]) w = c;
        return w;
    endfunction

    task automatic model_step();
        int w;
        int lo;
        bit take;
        if (g_clr) begin
            for (int c = 0; c < 4; c++) begin
                m_prev[c] = 0; m_pend[c] = 0; m_isr[c] = 0; m_mask[c] = 1;
            end
        end else begin
            w = m_win();
            take = ia.i_ack && ia.i_en && w >= 0;
            lo = -1;
            for (int c = 3; c >= 0; c--) if (m_isr[c]) lo = c;
            if (ia.i_ret && lo >= 0) m_isr[lo] = 0;
            if (take) m_isr[w] = 1;
            for (int c = 0; c < 4; c++) begin
                if (ia.edge_mode[c])
                    m_pend[c] = (m_pend[c] && !(take && w == c)) || (ia.irq_in[c] && !m_prev[c]);
                else
                    m_pend[c] = ia.irq_in[c];
                m_prev[c] = ia.irq_in[c];
                if (ia.mask_wr) m_mask[c] = ia.mask_in[c];
            end
        end
    endtask

    task automatic tick();
        @(posedge g_clk);
        model_step();
        #1;
    endtask

    task automatic set_a(input logic [3:0] irq, input logic ack, input logic ret);
        ia.irq_in = irq;
        ia.i_ack = ack;
        ia.i_ret = ret;
    endtask

    task automatic test_reset();
        g_clr = 1'b1; g_clr_b = 1'b1;
        ia.i_ack = 1'b1; ia.i_ret = 1'b1; ia.mask_wr = 1'b1; ia.mask_in = 4'h0; ia.i_en = 1'b1;
        tick(); tick();
        checks++; if (ia.i_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %0b exp 0", ia.i_pending); end
        checks++; if (ia.vector_out !== 8'h00) begin errors++; $display("FAIL reset_vector got %0h exp 00", ia.vector_out); end
        checks++; if (ia.isr_out !== 4'h0) begin errors++; $display("FAIL reset_isr got %0h exp 0", ia.isr_out); end
        checks++; if (ia.mask_out !== 4'hF) begin errors++; $display("FAIL reset_mask got %0h exp f", ia.mask_out); end
        checks++; if (ib.mask_out !== 8'hFF) begin errors++; $display("FAIL reset_mask_b got %0h exp ff", ib.mask_out); end
        g_clr = 1'b0; g_clr_b = 1'b0;
        set_a(4'h0, 1'b0, 1'b0); ia.mask_wr = 1'b0;
    endtask

    task automatic test_basic();
        ia.mask_wr = 1'b1; ia.mask_in = 4'h0; ia.edge_mode = 4'hF; ia.i_en = 1'b1;
        tick();
        ia.mask_wr = 1'b0;
        checks++; if (ia.mask_out !== 4'h0) begin errors++; $display("FAIL basic_unmask got %0h exp 0", ia.mask_out); end
        set_a(4'b0100, 1'b0, 1'b0); tick();
        set_a(4'b0000, 1'b0, 1'b0);
        checks++; if (ia.i_pending !== 1'b1) begin errors++; $display("FAIL basic_pending got %0b exp 1", ia.i_pending); end
        checks++; if (ia.vector_out !== 8'hF2) begin errors++; $display("FAIL basic_vector got %0h exp f2", ia.vector_out); end
        ia.i_en = 1'b0; #1;
        checks++; if (ia.i_pending !== 1'b0 || ia.vector_out !== 8'h00) begin errors++; $display("FAIL ien_gate got %0b/%0h exp 0/00", ia.i_pending, ia.vector_out); end
        ia.i_en = 1'b1; #1;
        set_a(4'b0000, 1'b1, 1'b0); tick();
        set_a(4'b0000, 1'b0, 1'b0);
        checks++; if (ia.isr_out !== 4'b0100) begin errors++; $display("FAIL basic_ack_isr got %0b exp 0100", ia.isr_out); end
        checks++; if (ia.i_pending !== 1'b0) begin errors++; $display("FAIL basic_ack_pending got %0b exp 0", ia.i_pending); end
    endtask

    task automatic test_nesting();
        set_a(4'b1000, 1'b0, 1'b0); tick();
        set_a(4'b0000, 1'b0, 1'b0);
        checks++; if (ia.i_pending !== 1'b0) begin errors++; $display("FAIL nest_lower_blocked got %0b exp 0", ia.i_pending); end
        set_a(4'b0001, 1'b0, 1'b0); tick();
        set_a(4'b0000, 1'b0, 1'b0);
        checks++; if (ia.i_pending !== 1'b1 || ia.vector_out !== 8'hF0) begin errors++; $display("FAIL nest_higher got %0b/%0h exp 1/f0", ia.i_pending, ia.vector_out); end
        set_a(4'b0000, 1'b1, 1'b0); tick();
        checks++; if (ia.isr_out !== 4'b0101) begin errors++; $display("FAIL nest_isr got %0b exp 0101", ia.isr_out); end
        set_a(4'b0000, 1'b0, 1'b1); tick();
        checks++; if (ia.isr_out !== 4'b0100) begin errors++; $display("FAIL nest_ret1 got %0b exp 0100", ia.isr_out); end
        tick();
        set_a(4'b0000, 1'b0, 1'b0);
        checks++; if (ia.isr_out !== 4'b0000) begin errors++; $display("FAIL nest_ret2 got %0b exp 0000", ia.isr_out); end
        checks++; if (ia.i_pending !== 1'b1 || ia.vector_out !== 8'hF3) begin errors++; $display("FAIL nest_ch3 got %0b/%0h exp 1/f3", ia.i_pending, ia.vector_out); end
        set_a(4'b0000, 1'b1, 1'b0); tick();
        set_a(4'b0000, 1'b0, 1'b1); tick();
        set_a(4'b0000, 1'b0, 1'b0);
    endtask

    task automatic test_level();
        ia.edge_mode = 4'b1101;
        set_a(4'b0010, 1'b0, 1'b0); tick();
        checks++; if (ia.i_pending !== 1'b1 || ia.vector_out !== 8'hF1) begin errors++; $display("FAIL level_pending got %0b/%0h exp 1/f1", ia.i_pending, ia.vector_out); end
        set_a(4'b0010, 1'b1, 1'b0); tick();
        checks++; if (ia.isr_out !== 4'b0010 || ia.i_pending !== 1'b0) begin errors++; $display("FAIL level_ack got %0b/%0b exp 0010/0", ia.isr_out, ia.i_pending); end
        set_a(4'b0010, 1'b0, 1'b1); tick();
        set_a(4'b0010, 1'b0, 1'b0);
        checks++; if (ia.i_pending !== 1'b1 || ia.vector_out !== 8'hF1) begin errors++; $display("FAIL level_reassert got %0b/%0h exp 1/f1", ia.i_pending, ia.vector_out); end
        set_a(4'b0000, 1'b0, 1'b0); tick();
        checks++; if (ia.i_pending !== 1'b0) begin errors++; $display("FAIL level_drop got %0b exp 0", ia.i_pending); end
    endtask

    task automatic test_mask();
        ia.edge_mode = 4'hF;
        ia.mask_wr = 1'b1; ia.mask_in = 4'b0010; tick();
        ia.mask_wr = 1'b0;
        checks++; if (ia.mask_out !== 4'b0010) begin errors++; $display("FAIL mask_write got %0b exp 0010", ia.mask_out); end
        set_a(4'b0010, 1'b0, 1'b0); tick();
        set_a(4'b0000, 1'b0, 1'b0);
        checks++; if (ia.i_pending !== 1'b0) begin errors++; $display("FAIL mask_blocks got %0b exp 0", ia.i_pending); end
        ia.mask_wr = 1'b1; ia.mask_in = 4'b0000; tick();
        ia.mask_wr = 1'b0;
        checks++; if (ia.i_pending !== 1'b1 || ia.vector_out !== 8'hF1) begin errors++; $display("FAIL mask_release got %0b/%0h exp 1/f1", ia.i_pending, ia.vector_out); end
    endtask

    task automatic test_ack_ret();
        set_a(4'b0000, 1'b1, 1'b0); tick();
        set_a(4'b0000, 1'b0, 1'b1); tick();
        set_a(4'b1000, 1'b0, 1'b0); tick();
        set_a(4'b0000, 1'b1, 1'b0); tick();
        checks++; if (ia.isr_out !== 4'b1000) begin errors++; $display("FAIL ackret_setup got %0b exp 1000", ia.isr_out); end
        set_a(4'b0010, 1'b0, 1'b0); tick();
        checks++; if (ia.i_pending !== 1'b1 || ia.vector_out !== 8'hF1) begin errors++; $display("FAIL ackret_pending got %0b/%0h exp 1/f1", ia.i_pending, ia.vector_out); end
        set_a(4'b0000, 1'b1, 1'b1); tick();
        set_a(4'b0000, 1'b0, 1'b0);
        checks++; if (ia.isr_out !== 4'b0010) begin errors++; $display("FAIL ackret_both got %0b exp 0010", ia.isr_out); end
    endtask

    task automatic test_ack_idle();
        set_a(4'b0000, 1'b1, 1'b0); tick();
        set_a(4'b0000, 1'b0, 1'b0);
        checks++; if (ia.isr_out !== 4'b0010 || ia.i_pending !== 1'b0) begin errors++; $display("FAIL ack_idle got %0b/%0b exp 0010/0", ia.isr_out, ia.i_pending); end
        set_a(4'b0000, 1'b0, 1'b1); tick();
        set_a(4'b0000, 1'b0, 1'b0);
    endtask

    task automatic test_clr_mid();
        set_a(4'b0010, 1'b0, 1'b0); tick();
        set_a(4'b0000, 1'b1, 1'b0); tick();
        set_a(4'b0001, 1'b0, 1'b0); tick();
        set_a(4'b0000, 1'b1, 1'b0); tick();
        checks++; if (ia.isr_out !== 4'b0011) begin errors++; $display("FAIL clr_setup got %0b exp 0011", ia.isr_out); end
        set_a(4'b1000, 1'b0, 1'b0); tick();
        g_clr = 1'b1; ia.mask_wr = 1'b1; ia.mask_in = 4'h0;
        set_a(4'b0001, 1'b1, 1'b1); tick();
        checks++; if (ia.isr_out !== 4'h0 || ia.mask_out !== 4'hF) begin errors++; $display("FAIL clr_state got %0h/%0h exp 0/f", ia.isr_out, ia.mask_out); end
        checks++; if (ia.i_pending !== 1'b0 || ia.vector_out !== 8'h00) begin errors++; $display("FAIL clr_outputs got %0b/%0h exp 0/00", ia.i_pending, ia.vector_out); end
        g_clr = 1'b0;
        set_a(4'b0001, 1'b0, 1'b0); tick();
        ia.mask_wr = 1'b0;
        checks++; if (ia.i_pending !== 1'b1 || ia.vector_out !== 8'hF0) begin errors++; $display("FAIL clr_held_edge got %0b/%0h exp 1/f0", ia.i_pending, ia.vector_out); end
        set_a(4'b0000, 1'b1, 1'b0); tick();
        set_a(4'b0000, 1'b0, 1'b1); tick();
        set_a(4'b0000, 1'b0, 1'b0);
        checks++; if (ia.i_pending !== 1'b0 || ia.isr_out !== 4'h0) begin errors++; $display("FAIL clr_pend_gone got %0b/%0h exp 0/0", ia.i_pending, ia.isr_out); end
    endtask

    task automatic test_wrap();
        ib.mask_wr = 1'b1; ib.mask_in = 8'h00; ib.edge_mode = 8'hFF; ib.i_en = 1'b1;
        tick();
        ib.mask_wr = 1'b0;
        ib.irq_in = 8'h08; tick();
        ib.irq_in = 8'h00;
        checks++; if (ib.i_pending !== 1'b1 || ib.vector_out !== 8'h02) begin errors++; $display("FAIL wrap_ch3 got %0b/%0h exp 1/02", ib.i_pending, ib.vector_out); end
        ib.i_ack = 1'b1; tick();
        ib.i_ack = 1'b0;
        checks++; if (ib.isr_out !== 8'h08) begin errors++; $display("FAIL wrap_isr got %0h exp 08", ib.isr_out); end
        ib.irq_in = 8'h80; tick();
        ib.irq_in = 8'h00;
        checks++; if (ib.i_pending !== 1'b0) begin errors++; $display("FAIL wrap_ch7_blocked got %0b exp 0", ib.i_pending); end
        ib.i_ret = 1'b1; tick();
        ib.i_ret = 1'b0;
        checks++; if (ib.i_pending !== 1'b1 || ib.vector_out !== 8'h0A) begin errors++; $display("FAIL wrap_ch7 got %0b/%0h exp 1/0a", ib.i_pending, ib.vector_out); end
    endtask

    task automatic test_random();
        int w;
        logic exp_p;
        logic [7:0] exp_v;
        logic [3:0] exp_isr;
        logic [3:0] exp_mask;
        for (int i = 0; i < 800; i++) begin
            g_clr = ($urandom_range(0, 59) == 0);
            ia.irq_in = 4'($urandom);
            if ($urandom_range(0, 19) == 0) ia.edge_mode = 4'($urandom);
            ia.mask_wr = ($urandom_range(0, 7) == 0);
            ia.mask_in = 4'($urandom) & 4'($urandom);
            ia.i_en = ($urandom_range(0, 5) != 0);
            ia.i_ack = ($urandom_range(0, 2) == 0);
            ia.i_ret = ($urandom_range(0, 3) == 0);
            tick();
            w = m_win();
            exp_p = ia.i_en && w >= 0;
            exp_v = exp_p ? 8'(8'hF0 + w) : 8'h00;
            for (int c = 0; c < 4; c++) begin
                exp_isr[c] = m_isr[c];
                exp_mask[c] = m_mask[c];
            end
            checks++; if (ia.i_pending !== exp_p) begin errors++; $display("FAIL rand_pending cyc %0d got %0b exp %0b", i, ia.i_pending, exp_p); end
            checks++; if (ia.vector_out !== exp_v) begin errors++; $display("FAIL rand_vector cyc %0d got %0h exp %0h", i, ia.vector_out, exp_v); end
            checks++; if (ia.isr_out !== exp_isr) begin errors++; $display("FAIL rand_isr cyc %0d got %0b exp %0b", i, ia.isr_out, exp_isr); end
            checks++; if (ia.mask_out !== exp_mask) begin errors++; $display("FAIL rand_mask cyc %0d got %0b exp %0b", i, ia.mask_out, exp_mask); end
        end
        g_clr = 1'b0;
    endtask

    initial begin
        ia.irq_in = '0; ia.edge_mode = '1; ia.mask_wr = 1'b0; ia.mask_in = '0;
        ia.i_en = 1'b0; ia.i_ack = 1'b0; ia.i_ret = 1'b0;
        ib.irq_in = '0; ib.edge_mode = '1; ib.mask_wr = 1'b0; ib.mask_in = '0;
        ib.i_en = 1'b0; ib.i_ack = 1'b0; ib.i_ret = 1'b0;
        test_reset();
        test_basic();
        test_nesting();
        test_level();
        test_mask();
        test_ack_ret();
        test_ack_idle();
        test_clr_mid();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
